// File: rtl/tdc_result_packer.sv
// tdc_result_packer: captures 40-bit TDC results into a small FIFO and
// serializes each one as an 8-byte framed packet on a valid/ready byte
// stream. Also generates the free-running arm pulse and counts overflow drops.
module tdc_result_packer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [39:0]              meas_in,
    input  logic                     meas_valid,
    input  logic [1:0]               tdc_state,
    input  logic                     auto_arm,
    output logic                     arm,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {S_IDLE, S_SEND} state_e;

    // FIFO storage and bookkeeping
    logic [39:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic          full, pop, push, drop;

    // Packet engine
    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    seq_q, seq_d;
    logic [39:0]   pkt_q, pkt_d;
    logic [7:0]    csum;

    // Misc registers
    logic          arm_q, arm_d;
    logic [7:0]    drop_q;

    // The FSM pops whenever it is idle and data is waiting; a pop frees a
    // slot in the same cycle, so a write into a full FIFO is still accepted.
    assign full = (count_q == LW'(DEPTH));
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign push = meas_valid && (!full || pop);
    assign drop = meas_valid && full && !pop;

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= meas_in;
    end

    // FIFO pointers, occupancy and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 8'h00;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'h01;
        end
    end

    // Packet FSM next-state: load on pop, step the byte index on handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        pkt_d   = pkt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    pkt_d   = mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        seq_d   = seq_q + 8'h01;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Packet FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            seq_q   <= 8'h00;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            pkt_q   <= pkt_d;
        end
    end

    // Checksum covers seq and the five measurement bytes, not the sync byte
    assign csum = seq_q ^ pkt_q[39:32] ^ pkt_q[31:24] ^ pkt_q[23:16]
                        ^ pkt_q[15:8]  ^ pkt_q[7:0];

    // Byte mux; driven only from registers so it cannot depend on tx_ready
    always_comb begin
        tx_data = 8'h00;
        if (state_q == S_SEND) begin
            case (idx_q)
                3'd0: tx_data = SYNC_BYTE;
                3'd1: tx_data = seq_q;
                3'd2: tx_data = pkt_q[39:32];
                3'd3: tx_data = pkt_q[31:24];
                3'd4: tx_data = pkt_q[23:16];
                3'd5: tx_data = pkt_q[15:8];
                3'd6: tx_data = pkt_q[7:0];
                3'd7: tx_data = csum;
                default: tx_data = 8'h00;
            endcase
        end
    end

    // Arm when idle with headroom; one slot stays free for the in-flight
    // result, and the previous-cycle term stops a back-to-back double pulse
    assign arm_d = auto_arm && (tdc_state == 2'd0)
                && (count_q < LW'(DEPTH - 1)) && !arm_q;

    // Arm pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arm_q <= 1'b0;
        else        arm_q <= arm_d;
    end

    assign arm        = arm_q;
    assign tx_valid   = (state_q == S_SEND);
    assign fifo_level = count_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_tdc_result_packer.sv
// Bench for tdc_result_packer: cycle-level queue model checked every cycle,
// a table of known packets, and directed multi-cycle corner cases.
module tb_tdc_result_packer;

    localparam int DEPTH = 4;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] meas_in = '0;
    logic        meas_valid = 1'b0;
    logic [1:0]  tdc_state = 2'd0;
    logic        auto_arm = 1'b0;
    logic        arm;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;

    tdc_result_packer #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .meas_in(meas_in), .meas_valid(meas_valid),
        .tdc_state(tdc_state), .auto_arm(auto_arm), .arm(arm),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [39:0] mq[$];
    bit          m_busy;
    bit [2:0]    m_idx;
    bit [7:0]    m_seq;
    logic [39:0] m_pkt;
    int          m_drop;
    bit          m_arm;
    int          m_pkts;
    logic [7:0]  cap[$];
    bit          tdc_auto = 1'b0;
    int          tdc_cnt = 0;

    typedef struct {
        logic [39:0] meas;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pbyte(input logic [39:0] m, input logic [7:0] s, input int i);
        logic [7:0] b[8];
        b[0] = SYNC;
        b[1] = s;
        for (int k = 0; k < 5; k++) b[2+k] = m[8*(4-k) +: 8];
        b[7] = 8'h00;
        for (int k = 1; k < 7; k++) b[7] = b[7] ^ b[k];
        return b[i];
    endfunction

    task automatic check_outputs();
        chk("tx_valid", 64'(tx_valid), 64'(m_busy));
        chk("tx_data", 64'(tx_data), m_busy ? 64'(pbyte(m_pkt, m_seq, int'(m_idx))) : 64'h0);
        chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("arm", 64'(arm), 64'(m_arm));
    endtask

    // Simple TDC core: IDLE -> ARMED -> MEASURING -> DONE(result pulse) -> IDLE
    task automatic tdc_step(input bit arm_seen);
        meas_valid = 1'b0;
        case (tdc_state)
            2'd0: if (arm_seen) begin tdc_state = 2'd1; tdc_cnt = int'($urandom_range(1, 3)); end
            2'd1: begin
                tdc_cnt--;
                if (tdc_cnt == 0) begin tdc_state = 2'd2; tdc_cnt = int'($urandom_range(1, 4)); end
            end
            2'd2: begin
                tdc_cnt--;
                if (tdc_cnt == 0) begin
                    tdc_state = 2'd3;
                    meas_valid = 1'b1;
                    meas_in = {8'($urandom), 32'($urandom)};
                end
            end
            default: tdc_state = 2'd0;
        endcase
    endtask

    // Advance model and DUT by one clock, then compare everything
    task automatic tick();
        bit pop, fire, push, arm_n, arm_pre;
        arm_pre = m_arm;
        fire  = m_busy && tx_ready;
        pop   = !m_busy && (mq.size() != 0);
        arm_n = auto_arm && (tdc_state == 2'd0) && (mq.size() < DEPTH - 1) && !m_arm;
        push  = meas_valid && ((mq.size() < DEPTH) || pop);
        if (meas_valid && !push && m_drop < 255) m_drop++;
        if (fire) cap.push_back(tx_data);
        if (pop) begin
            m_pkt  = mq.pop_front();
            m_busy = 1'b1;
            m_idx  = 3'd0;
        end else if (fire) begin
            if (m_idx == 3'd7) begin
                m_busy = 1'b0;
                m_seq++;
                m_pkts++;
            end else m_idx++;
        end
        if (push) mq.push_back(meas_in);
        m_arm = arm_n;
        @(posedge clk); #1;
        check_outputs();
        if (tdc_auto) tdc_step(arm_pre);
    endtask

    task automatic pulse(input logic [39:0] v);
        meas_in = v;
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n = 0;
        while (m_pkts < target && n < budget) begin tick(); n++; end
        chk("pkt_timeout", 64'(m_pkts >= target), 64'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        meas_valid = 1'b0;
        tdc_auto = 1'b0;
        tdc_state = 2'd0;
        auto_arm = 1'b0;
        mq.delete();
        m_busy = 0; m_idx = 0; m_seq = 0; m_drop = 0; m_arm = 0; m_pkts = 0;
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int arm_cnt, tv_cnt, base;
        logic [39:0] ov[$];
        logic [39:0] v;

        tbl[0] = '{40'h00_0000_0123, 64'hA5_00_00_00_00_01_23_22};
        tbl[1] = '{40'hFF_FFFF_FFFF, 64'hA5_01_FF_FF_FF_FF_FF_FE};
        tbl[2] = '{40'h12_3456_789A, 64'hA5_02_12_34_56_78_9A_90};
        tbl[3] = '{40'h00_0000_0000, 64'hA5_03_00_00_00_00_00_03};

        // Reset state
        do_reset();
        check_outputs();

        // Known packets with latency check
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cap.delete();
            pulse(tbl[i].meas);
            chk("lat_n1_valid", 64'(tx_valid), 64'h0);
            tick();
            chk("lat_n2_valid", 64'(tx_valid), 64'h1);
            wait_pkts(i + 1, 30);
            for (int b = 0; b < 8; b++)
                chk("tbl_byte", 64'(cap[b]), 64'(tbl[i].exp[8*(7-b) +: 8]));
            repeat (2) tick();
        end

        // Backpressure while byte3 is presented
        cap.delete();
        v = 40'hC3_5A_0F_F0_81;
        pulse(v);
        begin
            int n = 0;
            while (!(m_busy && m_idx == 3'd3) && n < 20) begin tick(); n++; end
            chk("bp_reach_b3", 64'(n < 20), 64'h1);
        end
        tx_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_hold_data", 64'(tx_data), 64'(pbyte(v, 8'd4, 3)));
        end
        tx_ready = 1'b1;
        wait_pkts(5, 30);
        for (int b = 0; b < 8; b++) chk("bp_byte", 64'(cap[b]), 64'(pbyte(v, 8'd4, b)));

        // Overflow: six results with the sink stalled
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v = {8'($urandom), 32'($urandom)};
            ov.push_back(v);
            pulse(v);
            tick();
            tick();
        end
        chk("ov_level", 64'(fifo_level), 64'd4);
        chk("ov_drop", 64'(drop_count), 64'd1);
        cap.delete();
        tx_ready = 1'b1;
        wait_pkts(5, 100);
        for (int p = 0; p < 5; p++) begin
            chk("ov_seq", 64'(cap[8*p+1]), 64'(p));
            chk("ov_order", 64'({cap[8*p+2], cap[8*p+3], cap[8*p+4], cap[8*p+5], cap[8*p+6]}),
                64'(ov[p]));
        end

        // Randomized traffic without auto-arm
        do_reset();
        for (int c = 0; c < 800; c++) begin
            meas_valid = ($urandom_range(0, 3) == 0);
            meas_in = {8'($urandom), 32'($urandom)};
            tx_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        meas_valid = 1'b0;

        // Auto-arm with the TDC model
        do_reset();
        tx_ready = 1'b1;
        auto_arm = 1'b1;
        tdc_auto = 1'b1;
        arm_cnt = 0;
        repeat (300) begin tick(); if (arm) arm_cnt++; end
        chk("arm_repeats", 64'(arm_cnt >= 10), 64'h1);
        chk("arm_no_drop", 64'(drop_count), 64'h0);
        tx_ready = 1'b0;
        repeat (200) tick();
        arm_cnt = 0;
        repeat (50) begin tick(); if (arm) arm_cnt++; end
        chk("arm_held_off", 64'(arm_cnt), 64'h0);
        chk("arm_full_level", 64'(fifo_level), 64'd3);
        chk("arm_full_drop", 64'(drop_count), 64'h0);

        // Sequence wrap over 257 packets
        do_reset();
        tx_ready = 1'b1;
        cap.delete();
        for (int i = 0; i < 257; i++) begin
            pulse({8'($urandom), 32'($urandom)});
            wait_pkts(i + 1, 40);
        end
        chk("wrap_seq_ff", 64'(cap[8*255+1]), 64'hFF);
        chk("wrap_seq_00", 64'(cap[8*256+1]), 64'h00);
        chk("wrap_drop", 64'(drop_count), 64'h0);

        // Reset in the middle of a packet
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) pulse({8'($urandom), 32'($urandom)});
        begin
            int n = 0;
            while (!(m_busy && m_idx == 3'd4) && n < 20) begin tick(); n++; end
            chk("rst_reach_b4", 64'(n < 20), 64'h1);
        end
        chk("rst_queued", 64'(fifo_level), 64'd2);
        do_reset();
        tx_ready = 1'b1;
        tv_cnt = 0;
        repeat (20) begin tick(); if (tx_valid) tv_cnt++; end
        chk("rst_no_valid", 64'(tv_cnt), 64'h0);
        cap.delete();
        base = m_pkts;
        pulse(40'h01_0203_0405);
        wait_pkts(base + 1, 30);
        chk("rst_seq0", 64'(cap[1]), 64'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdc_result_packer.md
# tdc_result_packer

Downstream consumer of the TDC core. It captures each 40-bit measurement on the core's single-cycle valid pulse and buffers it in a small FIFO. Each result is serialized as an 8-byte framed packet on a valid/ready byte stream that feeds the UART transmitter. The block also generates the core's `arm` pulse for free-running acquisition, gated by FIFO headroom, and counts results dropped on overflow.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, minimum 2.
- `SYNC_BYTE`, 8'hA5, first byte of every packet.

- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `meas_in`  in  40  measurement from TDC core; sampled only when `meas_valid`=1.
- `meas_valid`  in  1  one-cycle pulse; result present on `meas_in`.
- `tdc_state`  in  2  TDC core state (0=IDLE, 1=ARMED, 2=MEASURING, 3=DONE).
- `auto_arm`  in  1  level; enables automatic arming.
- `arm`  out  1  registered one-cycle arm pulse to the TDC core.
- `tx_data`  out  8  packet byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte when `tx_valid` & `tx_ready`.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `drop_count`  out  8  saturating count of results lost to a full FIFO.

## Operation
- FIFO write: on `meas_valid`=1 with level < DEPTH, `meas_in` is stored.
- Overflow: on `meas_valid`=1 with level = DEPTH and no pop in that cycle, the result is discarded, FIFO contents are unchanged, and `drop_count` increments, saturating at 255.
- Simultaneous write and pop: both take effect and the level is unchanged. A write into a full FIFO in a pop cycle is accepted.
- Packet FSM states:
  - IDLE: FIFO non-empty → pop the head into the packet register, byte index = 0, go to SEND. The pop does not depend on `tx_ready`.
  - SEND: `tx_valid`=1, `tx_data` = byte[index]. On handshake, index increments. On handshake of byte 7: `seq` increments, `tx_valid` drops, go to IDLE.
- Packet byte order:
  - byte0 = SYNC_BYTE
  - byte1 = `seq`
  - bytes 2..6 = measurement [39:32], [31:24], [23:16], [15:8], [7:0]
  - byte7 = XOR of bytes 1..6 (excludes the sync byte)
- `seq`: 8-bit packet counter, reset 0, wraps 255→0. It advances only on a completed packet.
- Arm logic: `arm` is registered high for exactly one cycle when all of the following hold:
  - `auto_arm`=1
  - `tdc_state`=0
  - `fifo_level` < DEPTH-1 (one slot stays reserved for the in-flight result)
  - `arm` was 0 in the previous cycle
- With `auto_arm`=0, `arm` stays 0. Drops are possible only when the TDC is armed externally.
- Checksum is computed on the packet register; no arithmetic carries; all widths are exact.

## Timing
- Reset values:
  - `arm`=0, `tx_valid`=0, `tx_data`=8'h00, `fifo_level`=0, `drop_count`=0
  - `seq`=0, FSM=IDLE, FIFO empty
- Reset mid-packet: the packet is abandoned, the FIFO is flushed, and no partial completion occurs after release.
- Latency:
  - `meas_valid` in cycle N → `fifo_level` updates in N+1.
  - Pop at the end of N+1 → `tx_valid`=1 with byte0 in N+2 (FSM idle, FIFO previously empty).
- Throughput: minimum 9 cycles per packet with `tx_ready` held 1 (8 bytes plus one IDLE cycle).
- Handshake:
  - Once asserted, `tx_valid` stays high and `tx_data` stays stable until accepted.
  - `tx_valid` never depends combinationally on `tx_ready`.
- `arm`: asserted in the cycle after its conditions are met. The TDC leaves IDLE in the following cycle, and the holdoff term prevents a double pulse.
- The `fifo_level` reported during SEND excludes the packet being transmitted.

## Test plan
- Single result: `meas_in`=40'h00_0000_0123 pulse, `tx_ready`=1 → bytes A5 00 00 00 00 01 23 22; `tx_valid` rises 2 cycles after the pulse; `seq` becomes 1.
- Backpressure: drop `tx_ready` for 5 cycles while byte3 is presented → byte3 held stable and valid throughout; no byte skipped or duplicated; checksum correct.
- Overflow (DEPTH=4, `tx_ready`=0): 6 pulses spaced 3 cycles apart → first result in the packet register, `fifo_level`=4, `drop_count`=1. Then `tx_ready`=1 → 5 packets, `seq` 0..4, in arrival order.
- Auto-arm: `auto_arm`=1, TDC model in IDLE → one-cycle `arm`. Re-armed after each DONE→IDLE. No arm while `fifo_level` ≥ 3 (`tx_ready`=0).
- Sequence wrap: 257 packets → byte1 of packet 256 is FF and of packet 257 is 00; `drop_count` stays 0.
- Reset mid-packet: assert `rst_n`=0 during byte4 with 2 entries queued → all outputs at reset values; after release, no `tx_valid` until a new `meas_valid`; next packet `seq`=00.
